// File: rtl/nco_phase_acc.sv
// nco_phase_acc: NCO phase accumulator feeding a sine/cosine LUT.
// Adds a tuning word every enabled clock, then adds a phase offset and optional
// LFSR dither, and registers the top ASZ phase bits as the LUT address.
// Tuning word and offset load through a valid/ready port. A loaded config is
// applied on the next cycle, or at the next accumulator wrap when cfg_sync=1.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   ena                  advance accumulator (and LFSR) this cycle
//   phase_clr            synchronous accumulator clear, priority over ena
//   cfg_freq, cfg_ofs    tuning word / phase offset (ACC_W bits, unsigned)
//   cfg_sync             1 = apply config at the next wrap, 0 = next cycle
//   cfg_valid/cfg_ready  config handshake (ready low while a config is pending)
//   a                    registered LUT address (phase MSBs)
//   wrap                 one-cycle strobe on accumulator overflow
module nco_phase_acc #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ASZ    = 10,
  parameter int unsigned DITHER = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             phase_clr,
  input  logic [ACC_W-1:0] cfg_freq,
  input  logic [ACC_W-1:0] cfg_ofs,
  input  logic             cfg_sync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [ASZ-1:0]   a,
  output logic             wrap
);

  localparam int unsigned LFSR_W = 15;
  // Dither MSB sits directly below the address LSB, so it can add at most +1 to a.
  localparam int unsigned DTH_SH = ACC_W - ASZ - LFSR_W;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  freq_act_q, freq_act_d;
  logic [ACC_W-1:0]  ofs_act_q, ofs_act_d;
  logic [ACC_W-1:0]  shd_freq_q, shd_freq_d;
  logic [ACC_W-1:0]  shd_ofs_q, shd_ofs_d;
  logic              shd_sync_q, shd_sync_d;
  logic              pend_q, pend_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [ASZ-1:0]    a_q, a_d;
  logic              wrap_q, wrap_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  logic [ACC_W:0]    sum;
  logic              carry;
  logic              xfer;
  logic              apply;
  logic [ACC_W-1:0]  dth;
  logic [ACC_W-1:0]  phase;

  // Next-state logic for accumulator, config shadow/apply, LFSR and address.
  always_comb begin
    acc_d      = acc_q;
    freq_act_d = freq_act_q;
    ofs_act_d  = ofs_act_q;
    shd_freq_d = shd_freq_q;
    shd_ofs_d  = shd_ofs_q;
    shd_sync_d = shd_sync_q;
    pend_d     = pend_q;
    lfsr_d     = lfsr_q;
    wrap_d     = 1'b0;

    sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'(freq_act_q);
    carry = sum[ACC_W];
    xfer  = cfg_valid && cfg_ready_q;
    // A synced config needs a real carry; a cleared accumulator does not count.
    apply = pend_q && (!shd_sync_q || (ena && !phase_clr && carry));

    if (phase_clr) begin
      acc_d = '0;
    end else if (ena) begin
      acc_d  = sum[ACC_W-1:0];
      wrap_d = carry;
    end

    // Fibonacci x^15 + x^14 + 1; the all-ones seed keeps it out of the zero state.
    if (ena) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2]};
    end

    // Ready is low whenever pend is set, so capture and apply never coincide.
    if (apply) begin
      freq_act_d = shd_freq_q;
      ofs_act_d  = shd_ofs_q;
      pend_d     = 1'b0;
    end else if (xfer) begin
      shd_freq_d = cfg_freq;
      shd_ofs_d  = cfg_ofs;
      shd_sync_d = cfg_sync;
      pend_d     = 1'b1;
    end
    cfg_ready_d = !pend_d;

    dth   = (DITHER != 0) ? (ACC_W'(lfsr_q) << DTH_SH) : '0;
    phase = acc_q + ofs_act_q + dth;
    a_d   = phase[ACC_W-1 -: ASZ];
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      freq_act_q  <= '0;
      ofs_act_q   <= '0;
      shd_freq_q  <= '0;
      shd_ofs_q   <= '0;
      shd_sync_q  <= 1'b0;
      pend_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      a_q         <= '0;
      wrap_q      <= 1'b0;
      lfsr_q      <= {LFSR_W{1'b1}};
    end else begin
      acc_q       <= acc_d;
      freq_act_q  <= freq_act_d;
      ofs_act_q   <= ofs_act_d;
      shd_freq_q  <= shd_freq_d;
      shd_ofs_q   <= shd_ofs_d;
      shd_sync_q  <= shd_sync_d;
      pend_q      <= pend_d;
      cfg_ready_q <= cfg_ready_d;
      a_q         <= a_d;
      wrap_q      <= wrap_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign a         = a_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// tb_nco_phase_acc: bench for nco_phase_acc, one DITHER=0 and one DITHER=1
// instance sharing all inputs. Directed vectors with hand-computed results, hand
// sequences for handshake/sync/clear/reset corners, and a cycle reference model.
module tb_nco_phase_acc;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        ena       = 1'b0;
  logic        phase_clr = 1'b0;
  logic        cfg_sync  = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_freq  = '0;
  logic [31:0] cfg_ofs   = '0;
  logic        rdy0, wrap0, rdy1, wrap1;
  logic [9:0]  a0, a1;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  nco_phase_acc #(.ACC_W(32), .ASZ(10), .DITHER(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .phase_clr(phase_clr),
    .cfg_freq(cfg_freq), .cfg_ofs(cfg_ofs), .cfg_sync(cfg_sync),
    .cfg_valid(cfg_valid), .cfg_ready(rdy0), .a(a0), .wrap(wrap0));

  nco_phase_acc #(.ACC_W(32), .ASZ(10), .DITHER(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ena(ena), .phase_clr(phase_clr),
    .cfg_freq(cfg_freq), .cfg_ofs(cfg_ofs), .cfg_sync(cfg_sync),
    .cfg_valid(cfg_valid), .cfg_ready(rdy1), .a(a1), .wrap(wrap1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the accumulator, config path and dither.
  logic [31:0] m_acc, m_freq, m_ofs, m_sfreq, m_sofs, m_p0, m_p1;
  logic        m_ssync, m_pend, m_ready, m_wrap;
  logic [9:0]  m_a0, m_a1;
  logic [14:0] m_lfsr;
  logic [32:0] m_sum;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_acc <= '0; m_freq <= '0; m_ofs <= '0; m_sfreq <= '0; m_sofs <= '0;
      m_ssync <= 1'b0; m_pend <= 1'b0; m_ready <= 1'b1; m_wrap <= 1'b0;
      m_a0 <= '0; m_a1 <= '0; m_lfsr <= 15'h7FFF;
    end else begin
      m_sum = {1'b0, m_acc} + {1'b0, m_freq};
      m_p0  = m_acc + m_ofs;
      m_p1  = m_p0 + ({17'd0, m_lfsr} << 7);
      m_a0 <= m_p0[31:22];
      m_a1 <= m_p1[31:22];
      if (phase_clr) begin
        m_acc <= '0; m_wrap <= 1'b0;
      end else if (ena) begin
        m_acc <= m_sum[31:0]; m_wrap <= m_sum[32];
      end else begin
        m_wrap <= 1'b0;
      end
      if (ena) m_lfsr <= {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
      if (m_pend) begin
        if (!m_ssync || (ena && !phase_clr && m_sum[32])) begin
          m_freq <= m_sfreq; m_ofs <= m_sofs; m_pend <= 1'b0; m_ready <= 1'b1;
        end
      end else if (cfg_valid && m_ready) begin
        m_sfreq <= cfg_freq; m_sofs <= cfg_ofs; m_ssync <= cfg_sync;
        m_pend <= 1'b1; m_ready <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on && reset_n) begin
      chk("model_a",        32'(a0),    32'(m_a0));
      chk("model_wrap",     32'(wrap0), 32'(m_wrap));
      chk("model_ready",    32'(rdy0),  32'(m_ready));
      chk("model_a_dither", 32'(a1),    32'(m_a1));
      chk("model_wrap_d",   32'(wrap1), 32'(m_wrap));
      chk("model_ready_d",  32'(rdy1),  32'(m_ready));
    end
  end

  function automatic logic carry_next();
    logic [32:0] s;
    s = {1'b0, m_acc} + {1'b0, m_freq};
    return s[32];
  endfunction

  // Present a config and hold valid until the cycle it is accepted.
  task automatic load(input logic [31:0] f, input logic [31:0] o, input logic s);
    int n;
    n = 0;
    cfg_freq = f; cfg_ofs = o; cfg_sync = s; cfg_valid = 1'b1;
    while (!rdy0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("load_accepted", 32'(rdy0), 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] freq;
    logic [31:0] ofs;
    int          n;
    logic [9:0]  exp_a;
    int          exp_wraps;
  } vec_t;

  vec_t        tbl[8];
  logic [9:0]  prev, d;
  int          wraps, cnt_a, cnt_b, n;
  bit          found;
  bit          s[32767+64];

  initial begin
    // {freq, ofs, enabled cycles from acc=0, final a, wraps seen}
    tbl[0] = '{32'h0040_0000, 32'h0000_0000,    5,   10'd5, 0};
    tbl[1] = '{32'h0040_0000, 32'h0000_0000, 1024,   10'd0, 1};
    tbl[2] = '{32'h0040_0000, 32'h4000_0000,    3, 10'd259, 0};
    tbl[3] = '{32'h0080_0000, 32'h0000_0000,  600, 10'd176, 1};
    tbl[4] = '{32'h0000_0000, 32'hC000_0000,   10, 10'd768, 0};
    tbl[5] = '{32'hFFC0_0000, 32'h0000_0000,    4, 10'd1020, 3};
    tbl[6] = '{32'h0000_0001, 32'hFFFF_FFFF,    1,   10'd0, 0};
    tbl[7] = '{32'h8000_0000, 32'h0000_0000,    3, 10'd512, 1};

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("reset_a",     32'(a0),    32'd0);
    chk("reset_wrap",  32'(wrap0), 32'd0);
    chk("reset_ready", 32'(rdy0),  32'd1);
    chk("reset_a_d",   32'(a1),    32'd0);
    reset_n = 1'b1;
    model_on = 1'b1;

    // Table vectors: clear, load immediately, run n enabled cycles, one idle cycle.
    foreach (tbl[i]) begin
      @(negedge clk); ena = 1'b0; phase_clr = 1'b1;
      @(negedge clk); phase_clr = 1'b0;
      load(tbl[i].freq, tbl[i].ofs, 1'b0);
      @(negedge clk);
      wraps = 0;
      ena = 1'b1;
      repeat (tbl[i].n) begin
        @(negedge clk);
        wraps += int'(wrap0);
      end
      ena = 1'b0;
      @(negedge clk);
      wraps += int'(wrap0);
      chk($sformatf("vec%0d_a", i),     32'(a0),    32'(tbl[i].exp_a));
      chk($sformatf("vec%0d_wraps", i), 32'(wraps), 32'(tbl[i].exp_wraps));
    end

    // Step-1 ramp: a counts 0..1023,0; wrap high while a shows 1023.
    phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0;
    load(32'h0040_0000, 32'h0, 1'b0);
    @(negedge clk);
    ena = 1'b1;
    for (int k = 1; k <= 1030; k++) begin
      @(negedge clk);
      chk("ramp_a",    32'(a0),    32'((k - 1) % 1024));
      chk("ramp_wrap", 32'(wrap0), 32'((k % 1024) == 0));
    end

    // Offset change while running: one +256 jump, step otherwise 1.
    load(32'h0040_0000, 32'h4000_0000, 1'b0);
    prev = a0; cnt_a = 0; cnt_b = 0;
    repeat (8) begin
      @(negedge clk);
      d = a0 - prev;
      if (d == 10'd1) cnt_a++;
      else if (d == 10'd257) cnt_b++;
      prev = a0;
    end
    chk("ofs_jump_count", 32'(cnt_b), 32'd1);
    chk("ofs_step_count", 32'(cnt_a), 32'd7);

    // Synced load: step 1 until wrap, ready low until then, second config stalls.
    load(32'h0080_0000, 32'h4000_0000, 1'b1);
    chk("sync_ready_low", 32'(rdy0), 32'd0);
    cfg_freq = 32'h00C0_0000; cfg_ofs = 32'h4000_0000; cfg_sync = 1'b0; cfg_valid = 1'b1;
    prev = a0; cnt_a = 0; cnt_b = 0; found = 1'b0; n = 0;
    while (!found && n < 1100) begin
      @(negedge clk);
      n++;
      d = a0 - prev;
      prev = a0;
      if (d != 10'd1) cnt_b++;
      if (wrap0) found = 1'b1;
      else if (rdy0) cnt_a++;
    end
    chk("sync_wrap_seen",      32'(found), 32'd1);
    chk("sync_ready_held_low", 32'(cnt_a), 32'd0);
    chk("sync_step1_pre_wrap", 32'(cnt_b), 32'd0);
    chk("sync_ready_at_wrap",  32'(rdy0),  32'd1);
    @(negedge clk); cfg_valid = 1'b0;
    prev = a0;
    @(negedge clk);
    d = a0 - prev;
    chk("sync_step2", 32'(d), 32'd2);
    repeat (3) @(negedge clk);
    prev = a0;
    @(negedge clk);
    d = a0 - prev;
    chk("stalled_cfg_applied_step3", 32'(d), 32'd3);

    // phase_clr with a pending synced config.
    load(32'h0040_0000, 32'h2000_0000, 1'b1);
    cfg_freq = 32'h0080_0000; cfg_ofs = 32'h2000_0000; cfg_sync = 1'b0; cfg_valid = 1'b1;
    n = 0;
    while (carry_next() && n < 10) begin @(negedge clk); n++; end
    phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0; ena = 1'b0;
    chk("clr_wrap", 32'(wrap0), 32'd0);
    @(negedge clk);
    chk("clr_a_is_ofs", 32'(a0),   32'd256);
    chk("clr_pend_kept", 32'(rdy0), 32'd0);
    ena = 1'b1;
    n = 0;
    while (!carry_next() && n < 1100) begin @(negedge clk); n++; end
    phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0;
    chk("clr_on_carry_wrap",     32'(wrap0), 32'd0);
    chk("clr_on_carry_deferred", 32'(rdy0),  32'd0);
    found = 1'b0; n = 0;
    while (!found && n < 1100) begin
      @(negedge clk);
      n++;
      if (wrap0) found = 1'b1;
    end
    chk("clr_later_wrap",  32'(found), 32'd1);
    chk("clr_later_apply", 32'(rdy0),  32'd1);
    @(negedge clk); cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    prev = a0;
    @(negedge clk);
    d = a0 - prev;
    chk("clr_second_cfg_step2", 32'(d), 32'd2);

    // Reset mid-run with a pending config.
    load(32'h0100_0000, 32'h1000_0000, 1'b1);
    chk("rst_pend_set", 32'(rdy0), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_a",     32'(a0),    32'd0);
    chk("rst_async_wrap",  32'(wrap0), 32'd0);
    chk("rst_async_ready", 32'(rdy0),  32'd1);
    chk("rst_async_a_d",   32'(a1),    32'd0);
    @(negedge clk); reset_n = 1'b1;
    cnt_a = 0;
    repeat (20) begin
      @(negedge clk);
      if (a0 != 10'd0 || wrap0) cnt_a++;
    end
    chk("rst_pend_discarded", 32'(cnt_a), 32'd0);
    chk("rst_ready_after",    32'(rdy0),  32'd1);

    // Dither: at most +1 on the address, and actually present.
    ena = 1'b0; phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0;
    load(32'h0040_0000, 32'h0020_0000, 1'b0);
    @(negedge clk);
    ena = 1'b1;
    cnt_a = 0; cnt_b = 0;
    repeat (1100) begin
      @(negedge clk);
      d = a1 - a0;
      if (d > 10'd1) cnt_a++;
      if (d == 10'd1) cnt_b++;
    end
    chk("dither_bound", 32'(cnt_a), 32'd0);
    chk("dither_active", 32'(cnt_b > 0), 32'd1);

    // Dither period: freq=0 and half-LSB offset make a1 equal the LFSR MSB stream.
    ena = 1'b0; phase_clr = 1'b1;
    @(negedge clk); phase_clr = 1'b0;
    load(32'h0, 32'h0020_0000, 1'b0);
    @(negedge clk);
    ena = 1'b1;
    repeat (2) @(negedge clk);
    cnt_a = 0;
    for (int i = 0; i < 32767 + 64; i++) begin
      @(negedge clk);
      s[i] = a1[0];
      if (a1 > 10'd1 || a0 != 10'd0) cnt_a++;
    end
    cnt_b = 0; n = 0;
    for (int i = 0; i < 64; i++) if (s[i] != s[i + 32767]) cnt_b++;
    for (int i = 0; i < 32767; i++) n += int'(s[i]);
    chk("lfsr_stream_range", 32'(cnt_a), 32'd0);
    chk("lfsr_period",       32'(cnt_b), 32'd0);
    chk("lfsr_ones",         32'(n),     32'd16384);

    model_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
